// File: rtl/mod_loop_counter.sv
// Modulo-(MAX+1) up/down counter with enable, clamped parallel load, terminal-count
// pulse and a one-shot run FSM. Define MOD_COUNTER_SAT_EN to saturate instead of wrap.
module mod_loop_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX     = 15,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;
  logic             term, step_ok, launch;
  logic [WIDTH-1:0] y_step;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    y_d     = y_q;
    tc_d    = 1'b0;
    state_d = state_q;

    term    = up ? (y_q == MAX_V) : (y_q == '0);
    step_ok = en && (!oneshot || (state_q == RUN));
    launch  = oneshot && start && (state_q != RUN);
    y_step  = up ? (y_q + 1'b1) : (y_q - 1'b1);

    if (launch) begin
      y_d     = up ? '0 : MAX_V;
      state_d = RUN;
    end else if (load) begin
      y_d = (din > MAX_V) ? MAX_V : din;
    end else if (step_ok) begin
      if (!term) begin
        y_d = y_step;
      end else if (oneshot) begin
        // Terminal step of a run: count freezes on the end value.
        tc_d    = 1'b1;
        state_d = DONE;
      end else begin
        tc_d = 1'b1;
`ifndef MOD_COUNTER_SAT_EN
        y_d  = up ? '0 : MAX_V;
`endif
      end
    end

    // Leaving one-shot mode drops the FSM back to IDLE from any state.
    if (!oneshot) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q     <= RST_V;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign y    = y_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mod_loop_counter.sv
// Bench for mod_loop_counter (WIDTH=4, MAX=9, RST_VAL=0): vector table, corner
// sequences and a randomized run checked against an arithmetic reference model.
module tb_mod_loop_counter;

  localparam int MAXC = 9;
`ifdef MOD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, up, oneshot, start, load;
  logic [3:0] din;
  logic [3:0] y;
  logic       tc, busy, done;

  int n_vec = 0;
  int n_err = 0;

  mod_loop_counter #(.WIDTH(4), .MAX(MAXC), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .oneshot(oneshot), .start(start),
    .load(load), .din(din), .y(y), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, up, os, st, ld;
    logic [3:0] din;
    logic [3:0] y;
    logic       tc, busy, done;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: count value and run/finished flags.
  int m_y;
  bit m_run, m_fin, m_tc;

  function automatic void add(input logic e, u, o, s, l, input logic [3:0] d,
                              input logic [3:0] ey, input logic et, eb, ed);
    vecs.push_back('{e, u, o, s, l, d, ey, et, eb, ed});
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got y=%0d tc=%b busy=%b done=%b, want y=%0d tc=%b busy=%b done=%b",
               name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input logic e, u, o, s, l, input logic [3:0] d);
    @(negedge clk);
    en = e; up = u; oneshot = o; start = s; load = l; din = d;
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input bit e, u, o, s, l, input int d);
    bit term = u ? (m_y == MAXC) : (m_y == 0);
    m_tc = 1'b0;
    if (o && s && !m_run) begin
      m_y = u ? 0 : MAXC;
      m_run = 1'b1;
      m_fin = 1'b0;
    end else if (l) begin
      m_y = (d > MAXC) ? MAXC : d;
    end else if (e && (!o || m_run)) begin
      if (term && o) begin
        m_tc = 1'b1;
        m_run = 1'b0;
        m_fin = 1'b1;
      end else if (term && SAT) begin
        m_tc = 1'b1;
      end else begin
        m_tc = term;
        m_y = (m_y + (u ? 1 : MAXC)) % (MAXC + 1);
      end
    end
    if (!o) begin
      m_run = 1'b0;
      m_fin = 1'b0;
    end
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; oneshot = 1'b0; start = 1'b0; load = 1'b0; din = '0;

    // Table: continuous wrap, load/clamp, enable gating, one-shot runs.
    add(0,1,0,0,0,0,  0,0,0,0);
    for (int i = 1; i <= 9; i++) add(1,1,0,0,0,0, 4'(i),0,0,0);
    add(1,1,0,0,0,0,  SAT ? 4'd9 : 4'd0, 1,0,0);
    add(1,1,0,0,1,1,  1,0,0,0);
    add(1,0,0,0,0,0,  0,0,0,0);
    add(1,0,0,0,0,0,  SAT ? 4'd0 : 4'd9, 1,0,0);
    add(1,0,0,0,0,0,  SAT ? 4'd0 : 4'd8, SAT,0,0);
    add(1,0,0,0,1,8,  8,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0, 8,0,0,0);
    add(1,1,0,0,1,6,  6,0,0,0);
    add(1,1,0,0,1,13, 9,0,0,0);
    add(1,1,0,0,0,0,  SAT ? 4'd9 : 4'd0, 1,0,0);
    add(0,1,0,0,1,3,  3,0,0,0);
    add(1,1,1,1,0,0,  0,0,1,0);
    for (int i = 1; i <= 9; i++) add(1,1,1,0,0,0, 4'(i),0,1,0);
    add(1,1,1,0,0,0,  9,1,0,1);
    add(1,1,1,0,0,0,  9,0,0,1);
    add(0,0,1,0,0,0,  9,0,0,1);
    add(1,1,1,1,0,0,  0,0,1,0);
    add(1,1,1,1,0,0,  1,0,1,0);
    add(0,1,1,0,0,0,  1,0,1,0);
    add(1,1,1,0,1,8,  8,0,1,0);
    add(1,1,1,0,0,0,  9,0,1,0);
    add(1,1,1,0,0,0,  9,1,0,1);
    add(1,1,1,0,1,2,  2,0,0,1);
    add(1,0,1,1,0,0,  9,0,1,0);
    add(1,0,1,0,0,0,  8,0,1,0);
    add(1,0,0,0,0,0,  7,0,0,0);
    add(1,0,1,0,0,0,  7,0,0,0);
    add(1,1,1,1,1,5,  0,0,1,0);
    add(0,1,0,1,0,0,  0,0,0,0);
    add(1,0,1,1,0,0,  9,0,1,0);
    add(1,0,1,0,1,0,  0,0,1,0);
    add(1,0,1,0,0,0,  0,1,0,1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {y, tc, busy, done}, 7'b0000_000);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].up, vecs[i].os, vecs[i].st, vecs[i].ld, vecs[i].din);
      check($sformatf("vec%0d", i), {y, tc, busy, done},
            {vecs[i].y, vecs[i].tc, vecs[i].busy, vecs[i].done});
    end

    // Continuous terminal at MAX held for two cycles, then reverse direction.
    apply(0,1,0,0,1,9);
    check("sat_load9", {y, tc, busy, done}, {4'd9, 3'b000});
    apply(1,1,0,0,0,0);
    check("sat_up1", {y, tc, busy, done}, {SAT ? 4'd9 : 4'd0, 3'b100});
    apply(1,1,0,0,0,0);
    check("sat_up2", {y, tc, busy, done}, {SAT ? 4'd9 : 4'd1, SAT, 2'b00});
    apply(1,0,0,0,0,0);
    check("sat_down", {y, tc, busy, done}, {SAT ? 4'd8 : 4'd0, 3'b000});

    // Asynchronous reset in the middle of a one-shot run.
    apply(1,1,1,1,0,0);
    repeat (5) apply(1,1,1,0,0,0);
    check("run_at5", {y, tc, busy, done}, {4'd5, 3'b010});
    #2 rst = 1'b0;
    #1 check("async_reset", {y, tc, busy, done}, 7'b0000_000);
    @(negedge clk);
    rst = 1'b1;
    apply(0,1,1,0,0,0);
    check("post_reset_hold", {y, tc, busy, done}, 7'b0000_000);
    apply(1,1,1,0,0,0);
    check("post_reset_needs_start", {y, tc, busy, done}, 7'b0000_000);

    // Randomized run against the reference model.
    m_y = 0; m_run = 1'b0; m_fin = 1'b0; m_tc = 1'b0;
    begin
      bit o = 1'b1, u = 1'b1;
      for (int i = 0; i < 800; i++) begin
        bit e, s, l;
        int d;
        if ($urandom_range(0, 39) == 0) o = ~o;
        if ($urandom_range(0, 9) == 0) u = ~u;
        e = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 7) == 0);
        l = ($urandom_range(0, 15) == 0);
        d = $urandom_range(0, 15);
        model(e, u, o, s, l, d);
        apply(e, u, o, s, l, 4'(d));
        check($sformatf("rand%0d", i), {y, tc, busy, done},
              {4'(m_y), m_tc, m_run, m_fin});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
